// File: rtl/mem_ctlr_pkg.sv
// Shared bus command / owner encodings and default widths for the memory controller.
`ifndef XLEN
`define XLEN 32
`endif

package mem_ctlr_pkg;

  localparam int XLEN_DEF = `XLEN;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWN_DCACHE = 1'b0,
    OWN_ICACHE = 1'b1
  } OWNER_T;

endpackage

// File: rtl/mem_ctlr_tag_table.sv
// Outstanding-load owner table: one valid bit and owner per memory tag (tag 0 unused).
// A set and a clear of the same tag in one cycle leave the new entry valid.
module mem_tag_table
  import mem_ctlr_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  OWNER_T           set_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output OWNER_T           lookup_owner
);

  localparam int NTAGS = 1 << TAG_W;

  logic [NTAGS-1:0] valid;
  OWNER_T           owner [NTAGS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NTAGS; i++) begin
      if (reset || i == 0) begin
        valid[i] <= 1'b0;
        owner[i] <= OWN_DCACHE;
      end else if (set_en && set_tag == TAG_W'(i)) begin
        valid[i] <= 1'b1;
        owner[i] <= set_owner;
      end else if (clr_en && clr_tag == TAG_W'(i)) begin
        valid[i] <= 1'b0;
      end
    end
  end

  assign lookup_valid = (lookup_tag != '0) && valid[lookup_tag];
  assign lookup_owner = owner[lookup_tag];

endmodule

// File: rtl/mem_ctlr.sv
// Arbitrates dcache/icache requests onto the tagged memory bus and routes completions
// back to whichever cache issued the load; icache is forced through after STARVE_MAX losses.
module mem_ctlr
  import mem_ctlr_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int TAG_W      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       dcache2ctlr_command,
  input  logic [XLEN-1:0]  dcache2ctlr_addr,
  input  logic [63:0]      dcache2ctlr_data,
  input  logic [1:0]       icache2ctlr_command,
  input  logic [XLEN-1:0]  icache2ctlr_addr,
  output logic [TAG_W-1:0] Ctlr2dcache_response,
  output logic [63:0]      Ctlr2dcache_data,
  output logic [TAG_W-1:0] Ctlr2dcache_tag,
  output logic [TAG_W-1:0] Ctlr2icache_response,
  output logic [63:0]      Ctlr2icache_data,
  output logic [TAG_W-1:0] Ctlr2icache_tag,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic            d_req, i_req, force_i;
  logic            grant_d, grant_i;
  logic [SC_W-1:0] starve_cnt;
  logic [SC_W-1:0] starve_nxt;
  logic            set_en;
  OWNER_T          set_owner;
  logic            hit;
  OWNER_T          hit_owner;

  assign d_req   = dcache2ctlr_command != BUS_NONE;
  assign i_req   = icache2ctlr_command != BUS_NONE;
  assign force_i = i_req && (starve_cnt == SC_W'(STARVE_MAX));
  assign grant_d = d_req && !force_i;
  assign grant_i = i_req && !grant_d;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_d) begin
      proc2mem_command = dcache2ctlr_command;
      proc2mem_addr    = dcache2ctlr_addr;
      proc2mem_data    = dcache2ctlr_data;
    end else if (grant_i) begin
      proc2mem_command = icache2ctlr_command;
      proc2mem_addr    = icache2ctlr_addr;
    end
  end

  assign Ctlr2dcache_response = grant_d ? mem2proc_response : '0;
  assign Ctlr2icache_response = grant_i ? mem2proc_response : '0;

  // Stores never complete to a cache, so only accepted loads claim a tag.
  assign set_en    = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
  assign set_owner = grant_i ? OWN_ICACHE : OWN_DCACHE;

  mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .set_en       (set_en),
    .set_tag      (mem2proc_response),
    .set_owner    (set_owner),
    .clr_en       (hit),
    .clr_tag      (mem2proc_tag),
    .lookup_tag   (mem2proc_tag),
    .lookup_valid (hit),
    .lookup_owner (hit_owner)
  );

  always_comb begin
    Ctlr2dcache_tag  = '0;
    Ctlr2dcache_data = '0;
    Ctlr2icache_tag  = '0;
    Ctlr2icache_data = '0;
    if (hit && hit_owner == OWN_DCACHE) begin
      Ctlr2dcache_tag  = mem2proc_tag;
      Ctlr2dcache_data = mem2proc_data;
    end else if (hit) begin
      Ctlr2icache_tag  = mem2proc_tag;
      Ctlr2icache_data = mem2proc_data;
    end
  end

  always_comb begin
    starve_nxt = '0;
    if (i_req && !grant_i && starve_cnt != SC_W'(STARVE_MAX))
      starve_nxt = starve_cnt + SC_W'(1);
    else if (i_req && !grant_i)
      starve_nxt = starve_cnt;
  end

  always_ff @(posedge clock) begin
    if (reset) starve_cnt <= '0;
    else       starve_cnt <= starve_nxt;
  end

endmodule
